// File: rtl/aqp_hctrl_events_if.sv
// Event-bus interface between the hand-controller event block and the CPU I/O block.
// The event block drives FIFO status/head, overflow and irq; the CPU side drives pop,
// overflow clear and interrupt enable.
interface aqp_hctrl_events_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          ev_valid;
   logic [8:0]    ev_data;
   logic          ev_rd;
   logic [CW-1:0] ev_count;
   logic          ovf;
   logic          ovf_clr;
   logic          irq_en;
   logic          irq;

   // Event source side (the debouncer / FIFO block)
   modport master (
      output ev_valid, ev_data, ev_count, ovf, irq,
      input  ev_rd, ovf_clr, irq_en
   );

   // Event consumer side (CPU I/O block)
   modport slave (
      input  ev_valid, ev_data, ev_count, ovf, irq,
      output ev_rd, ovf_clr, irq_en
   );
endinterface

// File: rtl/aqp_hctrl_events.sv
// Hand-controller event block: debounces the two raw active-low controller bytes on a
// slow sample tick, holds the stable copies, and queues every committed change in a small
// first-word-fall-through FIFO with overflow flag and interrupt request.
module aqp_hctrl_events #(
   parameter int TICK_DIV   = 1024,
   parameter int STABLE_CNT = 4,
   parameter int DEPTH      = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] hctrl1_raw,
   input  logic [7:0] hctrl2_raw,
   output logic [7:0] hctrl1_stable,
   output logic [7:0] hctrl2_stable,
   aqp_hctrl_events_if.master ev_bus
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // ---------------------------------------------------------------- sample tick
   logic [TW-1:0] tick_q;
   logic          tick_w;

   assign tick_w = (tick_q == TW'(TICK_DIV - 1));

   // Free-running sample counter, wraps at TICK_DIV-1
   always_ff @(posedge clk) begin
      if (reset || tick_w) tick_q <= '0;
      else                 tick_q <= tick_q + TW'(1);
   end

   // ---------------------------------------------------------------- debounce
   logic [7:0] raw_w    [2];
   logic [7:0] stable_w [2];
   logic [7:0] newval_w [2];
   logic [1:0] commit_w;

   assign raw_w[0]      = hctrl1_raw;
   assign raw_w[1]      = hctrl2_raw;
   assign hctrl1_stable = stable_w[0];
   assign hctrl2_stable = stable_w[1];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_deb
         logic [7:0] cand_q, cand_d;
         logic [7:0] stab_q, stab_d;
         logic [3:0] cnt_q, cnt_d;
         logic       commit_l;

         // Candidate/count update on each tick; commit when the count reaches settled
         always_comb begin
            cand_d   = cand_q;
            stab_d   = stab_q;
            cnt_d    = cnt_q;
            commit_l = 1'b0;
            if (tick_w) begin
               if (raw_w[gi] != cand_q) begin
                  cand_d = raw_w[gi];
                  cnt_d  = 4'd1;
               end else if (cnt_q < 4'(STABLE_CNT - 1)) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (cnt_q == 4'(STABLE_CNT - 1)) begin
                  cnt_d = 4'(STABLE_CNT);
                  if (cand_q != stab_q) begin
                     stab_d   = cand_q;
                     commit_l = 1'b1;
                  end
               end
            end
         end

         // Debounce state registers; reset leaves the filter settled on "no buttons"
         always_ff @(posedge clk) begin
            if (reset) begin
               cand_q <= 8'hFF;
               stab_q <= 8'hFF;
               cnt_q  <= 4'(STABLE_CNT);
            end else begin
               cand_q <= cand_d;
               stab_q <= stab_d;
               cnt_q  <= cnt_d;
            end
         end

         assign stable_w[gi] = stab_q;
         assign newval_w[gi] = stab_d;
         assign commit_w[gi] = commit_l;
      end
   endgenerate

   // ---------------------------------------------------------------- event push
   // ctrl1 has priority on a shared tick; ctrl2 is then deferred by one cycle via pend.
   // Its value is already in the stable register by then. TICK_DIV >= 4 guarantees the
   // deferred push never collides with the next tick.
   logic       pend_q, pend_d;
   logic       push_vld;
   logic [8:0] push_dat;

   // Select the event to push this cycle
   always_comb begin
      push_vld = 1'b0;
      push_dat = '0;
      pend_d   = commit_w[0] & commit_w[1];
      if (commit_w[0]) begin
         push_vld = 1'b1;
         push_dat = {1'b0, newval_w[0]};
      end else if (commit_w[1]) begin
         push_vld = 1'b1;
         push_dat = {1'b1, newval_w[1]};
      end else if (pend_q) begin
         push_vld = 1'b1;
         push_dat = {1'b1, stable_w[1]};
      end
   end

   // Deferred ctrl2 push flag
   always_ff @(posedge clk) begin
      if (reset) pend_q <= 1'b0;
      else       pend_q <= pend_d;
   end

   // ---------------------------------------------------------------- FIFO
   logic [8:0]    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          empty_w, full_w, pop_w, push_ok_w, ovf_set_w;
   logic          ovf_q;

   assign empty_w   = (count_q == '0);
   assign full_w    = (count_q == CW'(DEPTH));
   assign pop_w     = ev_bus.ev_rd & ~empty_w;
   // A full FIFO still accepts a push when the same cycle pops
   assign push_ok_w = push_vld & (~full_w | pop_w);
   assign ovf_set_w = push_vld & full_w & ~pop_w;

   // Occupancy bookkeeping
   always_comb begin
      count_d = count_q;
      case ({push_ok_w, pop_w})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage write; contents need no reset since the head is masked while empty
   always_ff @(posedge clk) begin
      if (push_ok_w) mem_q[wr_ptr_q] <= push_dat;
   end

   // Pointers and count; pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok_w) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_w)     rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
      end
   end

   // Sticky overflow; a new overflow beats a simultaneous clear
   always_ff @(posedge clk) begin
      if (reset)                ovf_q <= 1'b0;
      else if (ovf_set_w)       ovf_q <= 1'b1;
      else if (ev_bus.ovf_clr)  ovf_q <= 1'b0;
   end

   assign ev_bus.ev_valid = ~empty_w;
   assign ev_bus.ev_data  = empty_w ? 9'd0 : mem_q[rd_ptr_q];
   assign ev_bus.ev_count = count_q;
   assign ev_bus.ovf      = ovf_q;
   assign ev_bus.irq      = ~empty_w & ev_bus.irq_en;
endmodule

// File: tb/tb_aqp_hctrl_events.sv
// Directed bench for aqp_hctrl_events with TICK_DIV=4, STABLE_CNT=3, DEPTH=4.
// Expected events go into a scoreboard queue when the commit-causing stimulus is driven
// and are popped/compared as the bench drains the FIFO.
module tb_aqp_hctrl_events;
   localparam int TICK_DIV   = 4;
   localparam int STABLE_CNT = 3;
   localparam int DEPTH      = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] raw1, raw2;
   logic [7:0] st1, st2;

   aqp_hctrl_events_if #(.DEPTH(DEPTH)) ev_bus ();

   aqp_hctrl_events #(
      .TICK_DIV  (TICK_DIV),
      .STABLE_CNT(STABLE_CNT),
      .DEPTH     (DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .hctrl1_raw   (raw1),
      .hctrl2_raw   (raw2),
      .hctrl1_stable(st1),
      .hctrl2_stable(st2),
      .ev_bus       (ev_bus)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;   // edges since reset release; ticks act on multiples of TICK_DIV
   logic [8:0] exp_q [$];
   logic [7:0] exp_st1, exp_st2;
   logic       exp_ovf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic align();
      while (cyc % TICK_DIV != 0) step();
   endtask

   // Hold a new value on one controller until it commits; check timing and FIFO state
   task automatic hold(input int id, input logic [7:0] v);
      align();
      if (id == 1) raw1 = v; else raw2 = v;
      repeat (TICK_DIV * STABLE_CNT - 1) step();
      chk("pre_commit_stable", (id == 1) ? st1 : st2, (id == 1) ? exp_st1 : exp_st2);
      step();
      if (id == 1) exp_st1 = v; else exp_st2 = v;
      chk("commit_stable", (id == 1) ? st1 : st2, v);
      if (exp_q.size() < DEPTH) exp_q.push_back({(id == 2), v});
      else                      exp_ovf = 1'b1;
      chk("commit_count", 32'(ev_bus.ev_count), 32'(exp_q.size()));
      chk("commit_ovf", 32'(ev_bus.ovf), 32'(exp_ovf));
      $display("[TB] commit ctrl%0d value=%02h count=%0d", id, v, ev_bus.ev_count);
   endtask

   // Pop the head and compare against the scoreboard
   task automatic pop();
      logic [8:0] e;
      e = exp_q.pop_front();
      chk("pop_valid", 32'(ev_bus.ev_valid), 32'd1);
      chk("pop_data", 32'(ev_bus.ev_data), 32'(e));
      $display("[TB] pop ev_data=%03h expected=%03h", ev_bus.ev_data, e);
      ev_bus.ev_rd = 1'b1;
      step();
      ev_bus.ev_rd = 1'b0;
      chk("pop_count", 32'(ev_bus.ev_count), 32'(exp_q.size()));
   endtask

   initial begin
      reset          = 1'b1;
      raw1           = 8'hFF;
      raw2           = 8'hFF;
      ev_bus.ev_rd   = 1'b0;
      ev_bus.ovf_clr = 1'b0;
      ev_bus.irq_en  = 1'b1;
      exp_st1        = 8'hFF;
      exp_st2        = 8'hFF;
      exp_ovf        = 1'b0;

      // Reset state
      repeat (3) step();
      chk("rst_st1", 32'(st1), 32'hFF);
      chk("rst_st2", 32'(st2), 32'hFF);
      chk("rst_valid", 32'(ev_bus.ev_valid), 32'd0);
      chk("rst_count", 32'(ev_bus.ev_count), 32'd0);
      chk("rst_data", 32'(ev_bus.ev_data), 32'd0);
      chk("rst_ovf", 32'(ev_bus.ovf), 32'd0);
      chk("rst_irq", 32'(ev_bus.irq), 32'd0);
      reset = 1'b0;
      cyc   = 0;

      // Idle 20 ticks
      repeat (20 * TICK_DIV) step();
      chk("idle_st1", 32'(st1), 32'hFF);
      chk("idle_st2", 32'(st2), 32'hFF);
      chk("idle_valid", 32'(ev_bus.ev_valid), 32'd0);
      chk("idle_irq", 32'(ev_bus.irq), 32'd0);
      chk("idle_ovf", 32'(ev_bus.ovf), 32'd0);

      // Single ctrl1 change, irq gating
      hold(1, 8'hFE);
      chk("fe_valid", 32'(ev_bus.ev_valid), 32'd1);
      chk("fe_irq_en1", 32'(ev_bus.irq), 32'd1);
      ev_bus.irq_en = 1'b0;
      #1;
      chk("fe_irq_en0", 32'(ev_bus.irq), 32'd0);
      ev_bus.irq_en = 1'b1;
      pop();
      chk("fe_empty", 32'(ev_bus.ev_valid), 32'd0);

      // ctrl2 glitch for two ticks, then back to FF: no event
      align();
      raw2 = 8'h7F;
      repeat (2 * TICK_DIV) step();
      raw2 = 8'hFF;
      repeat (5 * TICK_DIV) step();
      chk("glitch_st2", 32'(st2), 32'hFF);
      chk("glitch_valid", 32'(ev_bus.ev_valid), 32'd0);

      // Both controllers commit on the same tick
      align();
      raw1 = 8'hF0;
      raw2 = 8'h0F;
      exp_q.push_back(9'h0F0);
      exp_q.push_back(9'h10F);
      repeat (TICK_DIV * STABLE_CNT) step();
      exp_st1 = 8'hF0;
      exp_st2 = 8'h0F;
      chk("both_st1", 32'(st1), 32'hF0);
      chk("both_st2", 32'(st2), 32'h0F);
      chk("both_count1", 32'(ev_bus.ev_count), 32'd1);
      chk("both_head", 32'(ev_bus.ev_data), 32'h0F0);
      step();
      chk("both_count2", 32'(ev_bus.ev_count), 32'd2);
      pop();
      pop();

      // Five commits without reads: fifth is dropped and sets ovf
      for (int i = 1; i <= 5; i++) hold(1, 8'(i));
      chk("full_count", 32'(ev_bus.ev_count), 32'd4);
      chk("full_ovf", 32'(ev_bus.ovf), 32'd1);

      // Overflow coincident with ovf_clr: set wins
      align();
      raw1 = 8'h06;
      repeat (TICK_DIV * STABLE_CNT - 1) step();
      ev_bus.ovf_clr = 1'b1;
      step();
      ev_bus.ovf_clr = 1'b0;
      exp_st1 = 8'h06;
      chk("setwins_ovf", 32'(ev_bus.ovf), 32'd1);
      chk("setwins_count", 32'(ev_bus.ev_count), 32'd4);

      // Drain: first four events in order
      repeat (4) pop();
      chk("drain_valid", 32'(ev_bus.ev_valid), 32'd0);
      chk("drain_irq", 32'(ev_bus.irq), 32'd0);
      ev_bus.ev_rd = 1'b1;
      step();
      ev_bus.ev_rd = 1'b0;
      chk("xrd_count", 32'(ev_bus.ev_count), 32'd0);
      chk("xrd_valid", 32'(ev_bus.ev_valid), 32'd0);
      chk("xrd_data", 32'(ev_bus.ev_data), 32'd0);

      // Reset with three events queued and a debounce in progress
      hold(1, 8'h11);
      hold(1, 8'h12);
      hold(1, 8'h13);
      align();
      raw2 = 8'h55;
      repeat (TICK_DIV + 1) step();
      reset = 1'b1;
      raw1  = 8'hFF;
      raw2  = 8'hFF;
      step();
      chk("mrst_count", 32'(ev_bus.ev_count), 32'd0);
      chk("mrst_valid", 32'(ev_bus.ev_valid), 32'd0);
      chk("mrst_st1", 32'(st1), 32'hFF);
      chk("mrst_st2", 32'(st2), 32'hFF);
      chk("mrst_ovf", 32'(ev_bus.ovf), 32'd0);
      exp_q.delete();
      reset = 1'b0;
      cyc   = 0;
      repeat (10 * TICK_DIV) step();
      chk("post_valid", 32'(ev_bus.ev_valid), 32'd0);
      chk("post_count", 32'(ev_bus.ev_count), 32'd0);
      chk("post_st1", 32'(st1), 32'hFF);
      chk("post_st2", 32'(st2), 32'hFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/aqp_hctrl_events.md
Name: aqp_hctrl_events

Overview:
- Sits directly downstream of the hand-controller serial reader.
- Consumes its two 8-bit raw, active-low controller bytes, debounces each, and holds a stable copy.
- Pushes every committed change into a small first-word-fall-through event FIFO that the CPU I/O block drains.
- Raises an interrupt request while events are pending, so software no longer has to poll the controllers.

Parameters:
- TICK_DIV, 1024: clk cycles per sample tick. Must be ≥4.
- STABLE_CNT, 4: consecutive equal samples required to commit a value. Must be ≥2 and ≤15.
- DEPTH, 4: event FIFO depth. Must be a power of 2, ≥2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- hctrl1_raw  in  8  raw controller 1 byte from the serial reader.
- hctrl2_raw  in  8  raw controller 2 byte from the serial reader.
- hctrl1_stable  out  8  debounced controller 1 value.
- hctrl2_stable  out  8  debounced controller 2 value.
- ev_valid  out  1  FIFO not empty.
- ev_data  out  9  FIFO head: bit8 = controller id (0 = ctrl1, 1 = ctrl2); bits 7:0 = new stable value.
- ev_rd  in  1  pop strobe, one cycle per event.
- ev_count  out  clog2(DEPTH)+1  number of entries in the FIFO.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  clears ovf.
- irq_en  in  1  interrupt enable.
- irq  out  1  interrupt request, equal to ev_valid & irq_en (combinational).

Behaviour:
- Reset values:
  - hctrl1_stable = hctrl2_stable = 8'hFF.
  - FIFO empty: ev_valid = 0, ev_count = 0, ev_data = 0.
  - ovf = 0, tick counter = 0, pending flag = 0.
  - Candidates = 8'hFF; sample counts = STABLE_CNT (settled).
- Reset mid-operation: all of the above take effect on the next clk edge. Queued events are discarded.
- Tick generation:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - A tick is a one-cycle pulse when the counter equals TICK_DIV-1.
- Per-controller debounce, evaluated on each tick:
  - raw != cand: cand <= raw, cnt <= 1.
  - raw == cand and cnt < STABLE_CNT-1: cnt <= cnt+1.
  - raw == cand and cnt == STABLE_CNT-1: cnt <= STABLE_CNT. If cand != stable, stable <= cand and an event is generated (commit).
  - raw == cand and cnt == STABLE_CNT: no change (saturated, no repeat events).
- Commit timing:
  - A held change commits on the STABLE_CNT-th tick that observes it. The capture tick counts as the first.
  - The new stable value is visible the cycle after that tick.
  - A change reverting to the current stable value before commit produces no event.
- Event push:
  - ctrl1 commit: pushed in the tick cycle.
  - ctrl2 commit: pushed in the tick cycle if ctrl1 did not commit on that tick. Otherwise a pending flag pushes it one cycle later.
  - FIFO order therefore always puts ctrl1 before ctrl2 for the same tick.
- FIFO:
  - First-word fall-through: ev_data shows the head whenever ev_valid = 1.
  - Pop on ev_rd while empty: ignored.
  - Push while full with no pop: event dropped, ovf <= 1, stored entries unchanged.
  - Push and pop while full: both accepted, count unchanged, no overflow.
  - Push and pop while empty: push accepted, pop ignored, count becomes 1.
  - Pointers wrap modulo DEPTH.
- ovf: ovf_clr clears it. If a set and a clear happen in the same cycle, set wins.
- Latency: irq follows ev_valid combinationally. ev_valid rises the cycle after the push.

Test Plan:
- Test parameters: TICK_DIV=4, STABLE_CNT=3, DEPTH=4.
- Reset, then idle with raw = FF/FF for 20 ticks -> stable = FF/FF; ev_valid = 0; irq = 0; ovf = 0.
- hctrl1_raw = 8'hFE held -> hctrl1_stable = FE the cycle after the 3rd tick; one event 0x0FE; ev_count = 1; irq = 1 with irq_en = 1, irq = 0 with irq_en = 0.
- hctrl2_raw glitches to 8'h7F for 2 ticks then returns to FF -> no event; hctrl2_stable stays FF.
- Both raws change on the same tick (ctrl1 = 8'hF0, ctrl2 = 8'h0F) -> two events in consecutive cycles, read out in order 0x0F0 then 0x10F; ev_count reaches 2.
- 5 commits without reads -> first 4 events retained in order; ovf = 1; ev_count = 4. Assert ovf_clr together with a new overflow -> ovf stays 1. Pop all 4 -> ev_valid = 0. Extra ev_rd -> no change.
- Assert reset with 3 events queued and a debounce in progress -> next cycle ev_count = 0, stable = FF/FF, ovf = 0. Raw inputs still FF/FF -> no events afterwards.
